mm_bus_arbiter: RTL and testbench

- Shares one simple memory-mapped (mm) register/memory port between two upstream mm requesters.
- Each requester is typically an AXI-Lite-to-mm bridge with independent wr/rd channels, so there are four request sources in total.
- Serialises all four sources onto a single downstream port using round-robin arbitration.
- A per-transfer timeout watchdog completes hung transfers so no AXI master can deadlock.

---
 rtl/mm_bus_arbiter_pkg.sv | 17 +
 rtl/mm_rr_pick.sv | 27 ++
 rtl/mm_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mm_bus_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mm_bus_arbiter_pkg.sv
// Shared definitions for the mm bus arbiter: source indices and FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mm_bus_arbiter_pkg;

  // Source numbering; bit 0 set means a read channel, bit 1 set means requester 1.
  localparam logic [1:0] SRC_S0_WR = 2'd0;
  localparam logic [1:0] SRC_S0_RD = 2'd1;
  localparam logic [1:0] SRC_S1_WR = 2'd2;
  localparam logic [1:0] SRC_S1_RD = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mm_rr_pick.sv
// Combinational 4-way round-robin picker: first requesting index at or after ptr, mod 4.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request bit is set.
module mm_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the closest requester to ptr is the last writer.
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mm_bus_arbiter.sv
// Round-robin arbiter sharing one mm port between two requesters' wr and rd channels.
// Latency: grant one cycle after request in IDLE; one transfer per two cycles at best.
// Backpressure: granted source held until downstream ready or watchdog expiry.
module mm_bus_arbiter
  import mm_bus_arbiter_pkg::*;
#(
  parameter int              ADDR_BITS      = 32,
  parameter int              DATA_BITS      = 32,
  parameter int              DATA_BYTES     = DATA_BITS / 8,
  parameter int              TIMEOUT_CYCLES = 256,
  parameter logic [DATA_BITS-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_BITS-1:0]  s0_wr_addr,
  input  logic [DATA_BITS-1:0]  s0_wr_dout,
  input  logic [DATA_BYTES-1:0] s0_wr_be,
  input  logic                  s0_wr_en,
  output logic                  s0_wr_ready,
  input  logic [ADDR_BITS-1:0]  s0_rd_addr,
  input  logic                  s0_rd_en,
  output logic [DATA_BITS-1:0]  s0_rd_din,
  output logic                  s0_rd_ready,
  input  logic [ADDR_BITS-1:0]  s1_wr_addr,
  input  logic [DATA_BITS-1:0]  s1_wr_dout,
  input  logic [DATA_BYTES-1:0] s1_wr_be,
  input  logic                  s1_wr_en,
  output logic                  s1_wr_ready,
  input  logic [ADDR_BITS-1:0]  s1_rd_addr,
  input  logic                  s1_rd_en,
  output logic [DATA_BITS-1:0]  s1_rd_din,
  output logic                  s1_rd_ready,
  output logic [ADDR_BITS-1:0]  m_wr_addr,
  output logic [DATA_BITS-1:0]  m_wr_dout,
  output logic [DATA_BYTES-1:0] m_wr_be,
  output logic                  m_wr_en,
  input  logic                  m_wr_ready,
  output logic [ADDR_BITS-1:0]  m_rd_addr,
  output logic                  m_rd_en,
  input  logic [DATA_BITS-1:0]  m_rd_din,
  input  logic                  m_rd_ready,
  output logic [1:0]            grant_idx,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  timeout_clr
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  arb_state_e  state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] cnt_q, cnt_d;
  logic        terr_q, terr_d;

  logic [3:0]  req;
  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic        g_is_rd, req_g, raw_en, done, expire, ready_g;
  logic [DATA_BITS-1:0] rd_g;

  assign req = {s1_rd_en, s1_wr_en, s0_rd_en, s0_wr_en};

  mm_rr_pick u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Odd source indices are read channels.
  assign g_is_rd     = grant_q[0];
  assign req_g       = req[grant_q];
  assign grant_idx   = grant_q;
  assign busy        = (state_q == BUSY);
  assign timeout_err = terr_q;

  // Downstream muxing, completion detection and routing of ready/data to the granted source.
  always_comb begin
    m_wr_addr   = '0;
    m_wr_dout   = '0;
    m_wr_be     = '0;
    m_wr_en     = 1'b0;
    m_rd_addr   = '0;
    m_rd_en     = 1'b0;
    s0_wr_ready = 1'b0;
    s0_rd_ready = 1'b0;
    s1_wr_ready = 1'b0;
    s1_rd_ready = 1'b0;
    s0_rd_din   = '0;
    s1_rd_din   = '0;
    raw_en      = 1'b0;
    done        = 1'b0;
    expire      = 1'b0;
    ready_g     = 1'b0;
    rd_g        = '0;
    if (state_q == BUSY) begin
      raw_en = req_g;
      if (!g_is_rd) begin
        m_wr_addr = grant_q[1] ? s1_wr_addr : s0_wr_addr;
        m_wr_dout = grant_q[1] ? s1_wr_dout : s0_wr_dout;
        m_wr_be   = grant_q[1] ? s1_wr_be   : s0_wr_be;
        done      = raw_en && m_wr_ready;
      end else begin
        m_rd_addr = grant_q[1] ? s1_rd_addr : s0_rd_addr;
        done      = raw_en && m_rd_ready;
      end
      // A downstream completion in the expiry cycle takes precedence over the watchdog.
      expire  = TO_EN && req_g && (cnt_q == TO_LAST) && !done;
      m_wr_en = !g_is_rd && raw_en && !expire;
      m_rd_en = g_is_rd && raw_en && !expire;
      ready_g = done || expire;
      rd_g    = expire ? TIMEOUT_RDATA : m_rd_din;
      case (grant_q)
        SRC_S0_WR: s0_wr_ready = ready_g;
        SRC_S0_RD: begin
          s0_rd_ready = ready_g;
          s0_rd_din   = rd_g;
        end
        SRC_S1_WR: s1_wr_ready = ready_g;
        default: begin
          s1_rd_ready = ready_g;
          s1_rd_din   = rd_g;
        end
      endcase
    end
  end

  // Next-state: grant in IDLE, retire on done/expiry, drop silently on a withdrawn request.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    terr_d   = terr_q;
    if (timeout_clr) terr_d = 1'b0;
    if (expire)      terr_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!req_g) begin
          state_d = IDLE;
        end else if (done || expire) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q  <= IDLE;
      rr_ptr_q <= 2'd0;
      grant_q  <= 2'd0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
    end
  end

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter with an 8-cycle watchdog.
// Latency: inputs change on the falling edge, outputs are sampled 1 ns later.
// Backpressure: the downstream ready is driven directly per step.
module tb_mm_bus_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] s0_wr_addr, s0_wr_dout, s0_rd_addr, s0_rd_din;
  logic [3:0]  s0_wr_be;
  logic        s0_wr_en, s0_wr_ready, s0_rd_en, s0_rd_ready;
  logic [31:0] s1_wr_addr, s1_wr_dout, s1_rd_addr, s1_rd_din;
  logic [3:0]  s1_wr_be;
  logic        s1_wr_en, s1_wr_ready, s1_rd_en, s1_rd_ready;
  logic [31:0] m_wr_addr, m_wr_dout, m_rd_addr, m_rd_din;
  logic [3:0]  m_wr_be;
  logic        m_wr_en, m_wr_ready, m_rd_en, m_rd_ready;
  logic [1:0]  grant_idx;
  logic        busy, timeout_err, timeout_clr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mm_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(arst_n),
    .s0_wr_addr(s0_wr_addr), .s0_wr_dout(s0_wr_dout), .s0_wr_be(s0_wr_be),
    .s0_wr_en(s0_wr_en), .s0_wr_ready(s0_wr_ready),
    .s0_rd_addr(s0_rd_addr), .s0_rd_en(s0_rd_en), .s0_rd_din(s0_rd_din), .s0_rd_ready(s0_rd_ready),
    .s1_wr_addr(s1_wr_addr), .s1_wr_dout(s1_wr_dout), .s1_wr_be(s1_wr_be),
    .s1_wr_en(s1_wr_en), .s1_wr_ready(s1_wr_ready),
    .s1_rd_addr(s1_rd_addr), .s1_rd_en(s1_rd_en), .s1_rd_din(s1_rd_din), .s1_rd_ready(s1_rd_ready),
    .m_wr_addr(m_wr_addr), .m_wr_dout(m_wr_dout), .m_wr_be(m_wr_be),
    .m_wr_en(m_wr_en), .m_wr_ready(m_wr_ready),
    .m_rd_addr(m_rd_addr), .m_rd_en(m_rd_en), .m_rd_din(m_rd_din), .m_rd_ready(m_rd_ready),
    .grant_idx(grant_idx), .busy(busy), .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [3:0] readies();
    return {s1_rd_ready, s1_wr_ready, s0_rd_ready, s0_wr_ready};
  endfunction

  initial begin
    #100000;
    $display("FAIL sim_watchdog: got running want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    arst_n = 1'b0;
    {s0_wr_addr, s0_wr_dout, s0_rd_addr, s1_wr_addr, s1_wr_dout, s1_rd_addr} = '0;
    s0_wr_be = '0; s1_wr_be = '0;
    {s0_wr_en, s0_rd_en, s1_wr_en, s1_rd_en} = '0;
    m_wr_ready = 1'b0; m_rd_ready = 1'b0; m_rd_din = '0; timeout_clr = 1'b0;

    // Reset state
    tick; tick; #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_men", {m_wr_en, m_rd_en}, 0);
    chk("rst_ready", readies(), 0);
    tick; arst_n = 1'b1;

    // Single write from s0, slave ready one cycle into BUSY
    tick; s0_wr_en = 1; s0_wr_addr = 32'h10; s0_wr_dout = 32'hA5A5_A5A5; s0_wr_be = 4'hF; #1;
    chk("wr_idle_men", m_wr_en, 0);
    tick; #1;
    chk("wr_grant", grant_idx, 0);
    chk("wr_men", m_wr_en, 1);
    chk("wr_addr", m_wr_addr, 32'h10);
    chk("wr_dout", m_wr_dout, 32'hA5A5_A5A5);
    chk("wr_be", m_wr_be, 4'hF);
    chk("wr_rden", m_rd_en, 0);
    chk("wr_noready", s0_wr_ready, 0);
    m_wr_ready = 1; #1;
    chk("wr_ready", readies(), 4'b0001);
    tick; s0_wr_en = 0; m_wr_ready = 0; #1;
    chk("wr_back_idle", busy, 0);
    chk("wr_ready_once", s0_wr_ready, 0);

    // s1 read (rr_ptr=1) returns downstream data
    tick; s1_rd_en = 1; s1_rd_addr = 32'h20; m_rd_din = 32'h1234_5678; m_rd_ready = 1;
    tick; #1;
    chk("rd_grant", grant_idx, 3);
    chk("rd_addr", m_rd_addr, 32'h20);
    chk("rd_men", {m_wr_en, m_rd_en}, 2'b01);
    chk("rd_ready", readies(), 4'b1000);
    chk("rd_din", s1_rd_din, 32'h1234_5678);
    chk("rd_s0_din", s0_rd_din, 0);
    tick; s1_rd_en = 0; m_rd_ready = 0;

    // All four requesting from reset, zero-wait slave
    arst_n = 0; tick; arst_n = 1;
    tick; {s0_wr_en, s0_rd_en, s1_wr_en, s1_rd_en} = 4'hF; m_wr_ready = 1; m_rd_ready = 1;
    for (int k = 0; k < 5; k++) begin
      tick; #1;
      chk("rr_grant", grant_idx, k % 4);
      chk("rr_busy", busy, 1);
      chk("rr_ready", readies(), 4'b0001 << (k % 4));
      chk("rr_onehot", 2'(m_wr_en) + 2'(m_rd_en), 1);
      tick;
      if (k == 4) {s0_wr_en, s0_rd_en, s1_wr_en, s1_rd_en} = 4'h0;
      #1;
      chk("rr_gap", busy, 0);
    end
    m_wr_ready = 0; m_rd_ready = 0;

    // Watchdog expiry on s0 read (rr_ptr=1), clear asserted in the expiry cycle
    tick; s0_rd_en = 1; s0_rd_addr = 32'h30; m_rd_din = 32'h55;
    for (int k = 1; k < 8; k++) begin
      tick; #1;
      chk("to_wait_ready", s0_rd_ready, 0);
      chk("to_wait_men", m_rd_en, 1);
    end
    tick; timeout_clr = 1; #1;
    chk("to_ready", s0_rd_ready, 1);
    chk("to_rdata", s0_rd_din, 32'hDEAD_BEEF);
    chk("to_men_forced", m_rd_en, 0);
    chk("to_err_pre", timeout_err, 0);
    tick; s0_rd_en = 0; timeout_clr = 0; #1;
    chk("to_err_setwins", timeout_err, 1);
    chk("to_idle", busy, 0);
    tick; timeout_clr = 1; #1;
    chk("to_err_sticky", timeout_err, 1);
    tick; timeout_clr = 0; s0_rd_en = 1; m_rd_ready = 1; m_rd_din = 32'hCAFE_F00D; #1;
    chk("to_err_clr", timeout_err, 0);
    tick; #1;
    chk("to_next_grant", grant_idx, 1);
    chk("to_next_ready", s0_rd_ready, 1);
    chk("to_next_din", s0_rd_din, 32'hCAFE_F00D);
    tick; s0_rd_en = 0; m_rd_ready = 0;

    // Slave ready exactly in the expiry cycle (s1 read, rr_ptr=2)
    tick; s1_rd_en = 1; s1_rd_addr = 32'h24; m_rd_din = 32'h77;
    for (int k = 1; k < 8; k++) begin
      tick; #1;
      chk("edge_wait_ready", s1_rd_ready, 0);
    end
    tick; m_rd_ready = 1; m_rd_din = 32'h0BAD_F00D; #1;
    chk("edge_ready", s1_rd_ready, 1);
    chk("edge_din", s1_rd_din, 32'h0BAD_F00D);
    chk("edge_men", m_rd_en, 1);
    tick; s1_rd_en = 0; m_rd_ready = 0; #1;
    chk("edge_noerr", timeout_err, 0);

    // Reset while BUSY on s1 write (rr_ptr=0), then re-grant
    tick; s1_wr_en = 1; s1_wr_addr = 32'h40; s1_wr_dout = 32'h0000_00AA; s1_wr_be = 4'h3;
    tick; #1;
    chk("rb_grant", grant_idx, 2);
    chk("rb_men", m_wr_en, 1);
    tick; arst_n = 0; #1;
    chk("rb_men_rst", m_wr_en, 0);
    chk("rb_busy_rst", busy, 0);
    chk("rb_addr_rst", m_wr_addr, 0);
    tick; arst_n = 1;
    tick; #1;
    chk("rb_regrant", grant_idx, 2);
    chk("rb_addr", m_wr_addr, 32'h40);
    m_wr_ready = 1; #1;
    chk("rb_ready", readies(), 4'b0100);
    tick; s1_wr_en = 0; m_wr_ready = 0;

    // Withdrawn request (rr_ptr=3): no ready, pointer unchanged
    tick; s0_wr_en = 1;
    tick; #1;
    chk("pv_grant", grant_idx, 0);
    s0_wr_en = 0; m_wr_ready = 1; #1;
    chk("pv_noready", s0_wr_ready, 0);
    chk("pv_men", m_wr_en, 0);
    tick; m_wr_ready = 0; s0_rd_en = 1; s1_rd_en = 1; m_rd_ready = 1; #1;
    chk("pv_idle", busy, 0);
    tick; #1;
    chk("pv_ptr_kept", grant_idx, 3);
    tick; s0_rd_en = 0; s1_rd_en = 0; m_rd_ready = 0;
    tick;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
